// File: rtl/mips_alu_mdu_if.sv
// MIPS ALU / multiply-divide unit bus.
// Request fields plus registered result and status.
interface mips_alu_mdu_if #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = $clog2(WIDTH)
) ();
   logic               start;
   logic [1:0]         alu_op;
   logic [5:0]         funct;
   logic [WIDTH-1:0]   a;
   logic [WIDTH-1:0]   b;
   logic [SHAMT_W-1:0] shamt;
   logic [WIDTH-1:0]   result;
   logic               zero;
   logic               busy;
   logic               done;
   logic               err;
   logic [WIDTH-1:0]   hi;
   logic [WIDTH-1:0]   lo;

   modport master (
      output start, alu_op, funct, a, b, shamt,
      input  result, zero, busy, done, err, hi, lo
   );

   modport slave (
      input  start, alu_op, funct, a, b, shamt,
      output result, zero, busy, done, err, hi, lo
   );
endinterface

// File: rtl/mips_alu_mdu.sv
// MIPS ALU with iterative MULTU/DIVU and HI/LO registers.
// Single-cycle ops finish at acceptance; mul/div iterate WIDTH cycles.
module mips_alu_mdu #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input logic             clk,
   input logic             rst,
   mips_alu_mdu_if.slave   bus
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt;
   logic [WIDTH-1:0]   op_a;
   logic [WIDTH-1:0]   op_b;
   logic               is_div;
   logic [2*WIDTH-1:0] p;
   logic [WIDTH-1:0]   result_q;
   logic               err_q;
   logic [WIDTH-1:0]   hi_q;
   logic [WIDTH-1:0]   lo_q;

   logic               dec_mul;
   logic               dec_div;
   logic               dec_err;
   logic [WIDTH-1:0]   dec_res;

   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;
   logic [WIDTH:0]     div_r;
   logic [WIDTH+1:0]   div_diff;
   logic               div_ge;
   logic [2*WIDTH-1:0] div_next;
   logic [2*WIDTH-1:0] step;

   // Decode the request and compute single-cycle results
   always_comb begin
      dec_mul = 1'b0;
      dec_div = 1'b0;
      dec_err = 1'b0;
      dec_res = '0;
      unique case (bus.alu_op)
         2'b00: dec_res = bus.a + bus.b;
         2'b01: dec_res = bus.a - bus.b;
         2'b10: begin
            unique case (bus.funct)
               6'h20: dec_res = bus.a + bus.b;
               6'h22: dec_res = bus.a - bus.b;
               6'h00: dec_res = bus.b << bus.shamt;
               6'h04: dec_res = bus.b << bus.a[SHAMT_W-1:0];
               6'h07: dec_res = $signed(bus.b) >>> bus.a[SHAMT_W-1:0];
               6'h10: dec_res = hi_q;
               6'h12: dec_res = lo_q;
               6'h19: dec_mul = 1'b1;
               6'h1B: begin
                  if (bus.b == '0) dec_err = 1'b1;
                  else             dec_div = 1'b1;
               end
               default: dec_err = 1'b1;
            endcase
         end
         default: dec_err = 1'b1;
      endcase
   end

   // One shift-add multiply step and one restoring divide step
   always_comb begin
      mul_sum  = {1'b0, p[2*WIDTH-1:WIDTH]} + {1'b0, op_a};
      mul_next = p[0] ? {mul_sum, p[WIDTH-1:1]}
                      : {1'b0, p[2*WIDTH-1:1]};
      div_r    = p[2*WIDTH-1:WIDTH-1];
      div_diff = {1'b0, div_r} - {2'b00, op_b};
      div_ge   = ~div_diff[WIDTH+1];
      div_next = {div_ge ? div_diff[WIDTH-1:0] : div_r[WIDTH-1:0],
                  p[WIDTH-2:0], div_ge};
      step     = is_div ? div_next : mul_next;
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (bus.start)
               state_nxt = (dec_mul || dec_div) ? RUN : DONE;
         end
         RUN: begin
            if (cnt == LAST) state_nxt = DONE;
         end
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Operand capture, iteration and architectural result update
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt      <= '0;
         op_a     <= '0;
         op_b     <= '0;
         is_div   <= 1'b0;
         p        <= '0;
         result_q <= '0;
         err_q    <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.start) begin
                  op_a   <= bus.a;
                  op_b   <= bus.b;
                  is_div <= dec_div;
                  cnt    <= '0;
                  p      <= dec_div ? {{WIDTH{1'b0}}, bus.a}
                                    : {{WIDTH{1'b0}}, bus.b};
                  if (!(dec_mul || dec_div)) begin
                     result_q <= dec_res;
                     err_q    <= dec_err;
                  end
               end
            end
            RUN: begin
               p   <= step;
               cnt <= cnt + 1'b1;
               if (cnt == LAST) begin
                  hi_q     <= step[2*WIDTH-1:WIDTH];
                  lo_q     <= step[WIDTH-1:0];
                  result_q <= step[WIDTH-1:0];
                  err_q    <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.result = result_q;
   assign bus.zero   = (result_q == '0);
   assign bus.busy   = (state != IDLE);
   assign bus.done   = (state == DONE);
   assign bus.err    = err_q;
   assign bus.hi     = hi_q;
   assign bus.lo     = lo_q;

endmodule

// File: tb/tb_mips_alu_mdu.sv
// Testbench for mips_alu_mdu: directed table, corner sequences and
// randomized ops against an arithmetic reference model.
module tb_mips_alu_mdu;

   localparam int W = 32;

   typedef struct {
      string       nm;
      logic [1:0]  op;
      logic [5:0]  fn;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  sh;
      logic [31:0] xr;
      logic        xe;
      int          xl;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;
   vec_t tbl[$];

   mips_alu_mdu_if #(.WIDTH(W)) bus ();

   mips_alu_mdu #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // Reference model: plain arithmetic on the architectural rules
   task automatic model(input logic [1:0] op, input logic [5:0] fn,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh, output logic [31:0] r,
                        output logic e, output int l);
      longint unsigned prod;
      r = '0;
      e = 1'b0;
      l = 1;
      if (op == 2'b00) r = a + b;
      else if (op == 2'b01) r = a - b;
      else if (op == 2'b11) e = 1'b1;
      else begin
         case (fn)
            6'h20: r = a + b;
            6'h22: r = a - b;
            6'h00: r = b << sh;
            6'h04: r = b << a[4:0];
            6'h07: r = $signed(b) >>> a[4:0];
            6'h10: r = m_hi;
            6'h12: r = m_lo;
            6'h19: begin
               prod = 64'(a) * 64'(b);
               m_hi = prod[63:32];
               m_lo = prod[31:0];
               r = m_lo;
               l = 33;
            end
            6'h1B: begin
               if (b == 0) e = 1'b1;
               else begin
                  m_lo = a / b;
                  m_hi = a % b;
                  r = m_lo;
                  l = 33;
               end
            end
            default: e = 1'b1;
         endcase
      end
   endtask

   task automatic run_op(input string nm, input logic [1:0] op,
                         input logic [5:0] fn, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] sh,
                         input logic [31:0] xr, input logic xe,
                         input int xl);
      int cyc = 0;
      int bsy = 0;
      @(negedge clk);
      bus.start  = 1'b1;
      bus.alu_op = op;
      bus.funct  = fn;
      bus.a      = a;
      bus.b      = b;
      bus.shamt  = sh;
      @(posedge clk);
      forever begin
         @(negedge clk);
         if (cyc == 0) begin
            bus.start = 1'b0;
            bus.a     = $urandom;
            bus.b     = $urandom;
            bus.shamt = 5'($urandom);
         end
         cyc++;
         if (bus.busy) bsy++;
         if (bus.done) break;
         if (cyc >= 100) begin
            chk({nm, " timeout"}, 64'(cyc), 64'(xl));
            return;
         end
      end
      chk({nm, " latency"}, 64'(cyc), 64'(xl));
      chk({nm, " busy"}, 64'(bsy), 64'(xl));
      chk({nm, " result"}, 64'(bus.result), 64'(xr));
      chk({nm, " err"}, 64'(bus.err), 64'(xe));
      chk({nm, " zero"}, 64'(bus.zero), 64'(xr == 0));
      chk({nm, " hi"}, 64'(bus.hi), 64'(m_hi));
      chk({nm, " lo"}, 64'(bus.lo), 64'(m_lo));
      @(negedge clk);
      chk({nm, " done pulse"}, 64'(bus.done), 64'(0));
   endtask

   initial begin
      logic [31:0] r, ra, rb;
      logic [1:0]  rop;
      logic [5:0]  rfn;
      logic [4:0]  rsh;
      logic        e;
      int          l, cyc, bsy, seen;
      logic [5:0]  fns [10];

      bus.start  = 1'b0;
      bus.alu_op = '0;
      bus.funct  = '0;
      bus.a      = '0;
      bus.b      = '0;
      bus.shamt  = '0;

      tbl.push_back('{"add_wrap", 2'b00, 6'h00, 32'hFFFFFFFF, 32'h1, 5'd0,
                      32'h0, 1'b0, 1});
      tbl.push_back('{"sub", 2'b01, 6'h00, 32'd5, 32'd7, 5'd0,
                      32'hFFFFFFFE, 1'b0, 1});
      tbl.push_back('{"srav", 2'b10, 6'h07, 32'd4, 32'h80000000, 5'd0,
                      32'hF8000000, 1'b0, 1});
      tbl.push_back('{"sll31", 2'b10, 6'h00, 32'd0, 32'd1, 5'd31,
                      32'h80000000, 1'b0, 1});
      tbl.push_back('{"sllv", 2'b10, 6'h04, 32'd36, 32'd3, 5'd0,
                      32'h30, 1'b0, 1});
      tbl.push_back('{"r_add", 2'b10, 6'h20, 32'd10, 32'd20, 5'd0,
                      32'd30, 1'b0, 1});
      tbl.push_back('{"r_sub", 2'b10, 6'h22, 32'd3, 32'd3, 5'd0,
                      32'd0, 1'b0, 1});
      tbl.push_back('{"op11", 2'b11, 6'h20, 32'd1, 32'd2, 5'd0,
                      32'd0, 1'b1, 1});
      tbl.push_back('{"funct3f", 2'b10, 6'h3F, 32'd1, 32'd2, 5'd0,
                      32'd0, 1'b1, 1});
      tbl.push_back('{"multu", 2'b10, 6'h19, 32'hFFFFFFFF, 32'd2, 5'd0,
                      32'hFFFFFFFE, 1'b0, 33});
      tbl.push_back('{"mfhi_mul", 2'b10, 6'h10, 32'd0, 32'd0, 5'd0,
                      32'd1, 1'b0, 1});
      tbl.push_back('{"divu", 2'b10, 6'h1B, 32'd100, 32'd7, 5'd0,
                      32'd14, 1'b0, 33});
      tbl.push_back('{"mfhi_div", 2'b10, 6'h10, 32'd0, 32'd0, 5'd0,
                      32'd2, 1'b0, 1});
      tbl.push_back('{"divu_b0", 2'b10, 6'h1B, 32'd9, 32'd0, 5'd0,
                      32'd0, 1'b1, 1});
      tbl.push_back('{"mflo_div", 2'b10, 6'h12, 32'd0, 32'd0, 5'd0,
                      32'd14, 1'b0, 1});

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst result", 64'(bus.result), 64'(0));
      chk("rst zero", 64'(bus.zero), 64'(1));
      chk("rst busy", 64'(bus.busy), 64'(0));
      chk("rst done", 64'(bus.done), 64'(0));
      chk("rst err", 64'(bus.err), 64'(0));
      chk("rst hi", 64'(bus.hi), 64'(0));
      chk("rst lo", 64'(bus.lo), 64'(0));
      rst = 1'b0;

      foreach (tbl[i]) begin
         model(tbl[i].op, tbl[i].fn, tbl[i].a, tbl[i].b, tbl[i].sh,
               r, e, l);
         run_op(tbl[i].nm, tbl[i].op, tbl[i].fn, tbl[i].a, tbl[i].b,
                tbl[i].sh, tbl[i].xr, tbl[i].xe, tbl[i].xl);
      end

      // MULTU with a second start raised mid-RUN
      @(negedge clk);
      bus.start  = 1'b1;
      bus.alu_op = 2'b10;
      bus.funct  = 6'h19;
      bus.a      = 32'hFFFFFFFF;
      bus.b      = 32'd2;
      @(posedge clk);
      cyc = 0;
      bsy = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) bus.start = 1'b0;
         if (cyc == 4) begin
            bus.start  = 1'b1;
            bus.alu_op = 2'b00;
            bus.a      = 32'd5;
            bus.b      = 32'd6;
         end
         if (cyc == 6) bus.start = 1'b0;
         if (bus.busy) bsy++;
         if (bus.done || cyc >= 100) break;
      end
      m_hi = 32'd1;
      m_lo = 32'hFFFFFFFE;
      chk("mid_start latency", 64'(cyc), 64'(33));
      chk("mid_start busy", 64'(bsy), 64'(33));
      chk("mid_start result", 64'(bus.result), 64'(32'hFFFFFFFE));
      chk("mid_start hi", 64'(bus.hi), 64'(1));
      chk("mid_start lo", 64'(bus.lo), 64'(32'hFFFFFFFE));
      @(negedge clk);
      chk("mid_start done pulse", 64'(bus.done), 64'(0));
      run_op("mfhi_after", 2'b10, 6'h10, 32'd0, 32'd0, 5'd0,
             32'd1, 1'b0, 1);

      // Randomized ops against the reference model
      fns = '{6'h20, 6'h22, 6'h00, 6'h04, 6'h07,
              6'h10, 6'h12, 6'h19, 6'h1B, 6'h3F};
      for (int k = 0; k < 150; k++) begin
         l   = $urandom_range(0, 19);
         rop = (l < 2) ? 2'b00 : (l < 4) ? 2'b01 :
               (l == 4) ? 2'b11 : 2'b10;
         rfn = fns[$urandom_range(0, 9)];
         if ($urandom_range(0, 9) == 0) rfn = 6'($urandom);
         ra  = $urandom;
         rb  = $urandom;
         if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(0, 31);
         if ($urandom_range(0, 7) == 0) rb = '0;
         rsh = 5'($urandom);
         model(rop, rfn, ra, rb, rsh, r, e, l);
         run_op($sformatf("rand%0d", k), rop, rfn, ra, rb, rsh, r, e, l);
      end

      // Reset in cycle 10 of a MULTU aborts it
      @(negedge clk);
      bus.start  = 1'b1;
      bus.alu_op = 2'b10;
      bus.funct  = 6'h19;
      bus.a      = 32'h12345678;
      bus.b      = 32'h9ABCDEF0;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (8) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      m_hi = '0;
      m_lo = '0;
      chk("abort busy", 64'(bus.busy), 64'(0));
      chk("abort hi", 64'(bus.hi), 64'(0));
      chk("abort lo", 64'(bus.lo), 64'(0));
      chk("abort result", 64'(bus.result), 64'(0));
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.done) seen++;
      end
      chk("abort no done", 64'(seen), 64'(0));
      run_op("mflo_abort", 2'b10, 6'h12, 32'd0, 32'd0, 5'd0,
             32'd0, 1'b0, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mips_alu_mdu.md
MIPS_ALU_MDU -- requirements
Module: mips_alu_mdu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width; legal values are even and at least 8.
REQ-002 SHALL have parameter SHAMT_W, default $clog2(WIDTH), shift-amount width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-005 SHALL have port start, input, 1, operation request; sampled only in IDLE.
REQ-006 SHALL have port alu_op, input, 2: 00 ADD, 01 SUB, 10 R-type (use funct), 11 illegal.
REQ-007 SHALL have port funct, input, 6, R-type function: 0x20 ADD, 0x22 SUB, 0x00 SLL, 0x04 SLLV, 0x07 SRAV, 0x10 MFHI, 0x12 MFLO, 0x19 MULTU, 0x1B DIVU.
REQ-008 SHALL have port a, input, WIDTH, operand rs.
REQ-009 SHALL have port b, input, WIDTH, operand rt.
REQ-010 SHALL have port shamt, input, SHAMT_W, immediate shift amount.
REQ-011 SHALL have port result, output, WIDTH, registered result.
REQ-012 SHALL have port zero, output, 1, high when result equals 0.
REQ-013 SHALL have port busy, output, 1, high in RUN and DONE.
REQ-014 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-015 SHALL have port err, output, 1, illegal-op or divide-by-zero flag, valid with done.
REQ-016 SHALL have ports hi and lo, output, WIDTH each, architectural HI/LO registers.

Function
REQ-017 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE; start is accepted only in IDLE; start in RUN or DONE is ignored.
REQ-018 SHALL register alu_op, funct, a, b and shamt on acceptance; input changes after acceptance do not affect the operation.
REQ-019 For single-cycle ops (ADD, SUB, SLL, SLLV, SRAV, MFHI, MFLO, illegal), SHALL go IDLE -> DONE, with done high in the cycle after acceptance (latency 1).
REQ-020 ADD/SUB SHALL compute a+b and a-b modulo 2^WIDTH; overflow wraps and is not flagged.
REQ-021 SLL SHALL give b << shamt.
REQ-022 SLLV SHALL give b << a[SHAMT_W-1:0].
REQ-023 SRAV SHALL give b arithmetic-shifted right by a[SHAMT_W-1:0].
REQ-024 MFHI/MFLO SHALL return the current hi/lo value.
REQ-025 MULTU SHALL be an unsigned shift-add multiply over exactly WIDTH RUN cycles, with done in cycle WIDTH+1 after acceptance; then {hi,lo} = a*b (2*WIDTH bits) and result = lo.
REQ-026 DIVU SHALL be unsigned restoring division over exactly WIDTH RUN cycles, with done in cycle WIDTH+1; then lo = a/b, hi = a%b and result = lo.
REQ-027 DIVU with b==0 SHALL skip RUN and go to DONE in 1 cycle with err=1 and result=0; hi/lo are unchanged.
REQ-028 alu_op 11 or an undefined funct under R-type SHALL complete in 1 cycle with err=1 and result=0; hi/lo are unchanged.
REQ-029 hi/lo SHALL update only at the DONE transition of a successful MULTU/DIVU; intermediate partial values are not visible on hi/lo.
REQ-030 result, zero and err SHALL hold their last values until the next completion.
REQ-031 done SHALL return low after one cycle; a new start is accepted earliest in the cycle after done.

Reset
REQ-032 When rst=1, the FSM SHALL enter IDLE and result, hi and lo SHALL clear to 0; zero=1; busy=0, done=0, err=0.
REQ-033 rst SHALL take priority over start and over any in-flight operation; rst during RUN aborts the operation with no done pulse and hi/lo left at 0.

Verification
REQ-034 WIDTH=32, ADD a=0xFFFFFFFF b=1, start -> next cycle done=1, result=0, zero=1, err=0.
REQ-035 SRAV a=4 b=0x80000000 -> result=0xF8000000 after 1 cycle; SLL shamt=31 b=1 -> 0x80000000.
REQ-036 MULTU a=0xFFFFFFFF b=2, with start re-asserted mid-RUN -> the second start is ignored, busy=1 for 33 cycles, done in cycle 33, hi=1, lo=0xFFFFFFFE, result=0xFFFFFFFE; MFHI then returns 1.
REQ-037 DIVU a=100 b=7 -> done in cycle 33, lo=14, hi=2; DIVU b=0 -> done in cycle 1, err=1, hi/lo unchanged.
REQ-038 alu_op=10 funct=0x3F -> err=1, result=0 in 1 cycle; rst asserted in cycle 10 of a MULTU -> no done, busy=0, hi=lo=0.
